// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch FSM state encoding
package cpu_pkg;

  localparam int PC_W     = 4;
  localparam int INSTR_W  = 8;
  localparam int RESET_PC = 0;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ir_reg.sv
// rtl/fetch_ir_reg.sv - fetch/decode instruction register with load, flush and drain
module fetch_ir_reg #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_drain,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_ir,
  output logic [PC_W-1:0]    o_ir_pc,
  output logic               o_valid
);

  // Flush beats load beats drain; flush only kills the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ir    <= '0;
      o_ir_pc <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_ir    <= i_instr;
      o_ir_pc <= i_pc;
      o_valid <= 1'b1;
    end else if (i_drain) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, warmup/run/halt FSM, IR handshake, fetch counter
module fetch_unit #(
  parameter int PC_W     = 4,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instruction_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic [PC_W-1:0]    ir_pc_o,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic               halted_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);
  import cpu_pkg::*;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_adv;
  logic             w_fetch;
  logic             w_drain;
  logic             w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WARMUP;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WARMUP: w_state_nxt = ST_RUN;
      ST_RUN:    if (halt_i) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_WARMUP;
    endcase
  end

  // A halted fetch still lets the held IR drain to decode.
  assign w_adv   = (r_state == ST_RUN) & (~ir_valid_o | ir_ready_i);
  assign w_fetch = ~redirect_i & w_adv & ~halt_i;
  assign w_drain = ~redirect_i & ~w_fetch & ir_valid_o & ir_ready_i;
  assign w_hs    = ir_valid_o & ir_ready_i & ~redirect_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pc <= PC_W'(RESET_PC);
    else if (redirect_i) r_pc <= redirect_pc_i;
    else if (w_fetch)    r_pc <= r_pc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (w_hs && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  fetch_ir_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ir (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_fetch),
    .i_flush (redirect_i),
    .i_drain (w_drain),
    .i_instr (instruction_i),
    .i_pc    (r_pc),
    .o_ir    (ir_o),
    .o_ir_pc (ir_pc_o),
    .o_valid (ir_valid_o)
  );

  assign pc_o        = r_pc;
  assign halted_o    = (r_state == ST_HALTED);
  assign fetch_cnt_o = r_cnt;

endmodule
